// File: rtl/audio_i2s_clkgen.sv
// audio_i2s_clkgen: PLL lock qualification plus I2S master clock and
// serial data generation, fed one stereo pair per frame by the mixer.
module audio_i2s_clkgen #(
  parameter int BCLK_DIV  = 22,
  parameter int DATA_W    = 24,
  parameter int SLOT_W    = 32,
  parameter int LOCK_HOLD = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              audio_ready,
  output logic              underrun
);

  localparam int FW  = 2 * SLOT_W;
  localparam int BW  = $clog2(FW);
  localparam int DVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CW  = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    RUN
  } state_t;

  state_t state;
  state_t state_n;

  logic           lock_m;
  logic           lock_s;
  logic [CW-1:0]  qcnt;
  logic [DVW-1:0] div;
  logic [BW-1:0]  bitcnt;
  logic [BW-1:0]  bit_nx;
  logic [BW-1:0]  idx;
  logic [FW-1:0]  frame;
  logic [FW-1:0]  hold;
  logic [FW-1:0]  pair;
  logic           full;
  logic           run;
  logic           enter;
  logic           wrap;
  logic           fall;
  logic           load;
  logic           accept;

  // state register, lock synchronizer and qualification counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      state       <= IDLE;
      qcnt        <= '0;
      audio_ready <= 1'b0;
    end else begin
      lock_m      <= pll_locked;
      lock_s      <= lock_m;
      state       <= state_n;
      qcnt        <= (state == QUAL && lock_s) ? qcnt + CW'(1) : '0;
      audio_ready <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (lock_s) state_n = QUAL;
      QUAL: begin
        if (!lock_s)
          state_n = IDLE;
        else if (qcnt == CW'(LOCK_HOLD - 1))
          state_n = RUN;
      end
      RUN:  if (!lock_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    run     = (state == RUN);
    enter   = (state_n == RUN) && !run;
    s_ready = run && !full;
    accept  = s_valid && s_ready;
    wrap    = (div == DVW'(BCLK_DIV - 1));
    fall    = wrap && i2s_bclk;
    bit_nx  = (bitcnt == BW'(FW - 1)) ? '0 : bitcnt + BW'(1);
    // one-bit I2S delay: slot bit b carries frame bit FW-b
    idx     = (bit_nx == '0) ? '0
            : BW'(FW - 1) - (bit_nx - BW'(1));
    load    = fall && (bit_nx == '0);
    pair    = (FW'(s_left) << (FW - DATA_W))
            | (FW'(s_right) << (SLOT_W - DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst || state_n != RUN) begin
      div       <= '0;
      bitcnt    <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
      frame     <= '0;
      hold      <= '0;
      full      <= 1'b0;
    end else if (enter) begin
      div       <= '0;
      bitcnt    <= BW'(FW - 1);
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
      frame     <= '0;
    end else begin
      underrun <= 1'b0;
      div      <= wrap ? '0 : div + DVW'(1);
      if (wrap)
        i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bitcnt    <= bit_nx;
        i2s_lrclk <= (bit_nx >= BW'(SLOT_W));
        i2s_sdata <= frame[idx];
      end
      // load sees the holding register before this cycle's accept
      if (load) begin
        frame    <= full ? hold : '0;
        underrun <= !full;
      end
      if (accept)
        hold <= pair;
      full <= (full && !load) || accept;
    end
  end

endmodule

// File: tb/tb_audio_i2s_clkgen.sv
// Bench for audio_i2s_clkgen: frame-level model of lock qualification,
// I2S timing and the sample queue, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_audio_i2s_clkgen;

  localparam int BCLK_DIV  = 2;
  localparam int DATA_W    = 24;
  localparam int SLOT_W    = 32;
  localparam int LOCK_HOLD = 8;
  localparam int FW        = 2 * SLOT_W;
  localparam int BPER      = 2 * BCLK_DIV;
  localparam int PADW      = SLOT_W - DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pll_locked = 1'b0;
  logic [DATA_W-1:0] s_left = '0;
  logic [DATA_W-1:0] s_right = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              i2s_bclk;
  logic              i2s_lrclk;
  logic              i2s_sdata;
  logic              audio_ready;
  logic              underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  audio_i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV),
    .DATA_W   (DATA_W),
    .SLOT_W   (SLOT_W),
    .LOCK_HOLD(LOCK_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .s_left     (s_left),
    .s_right    (s_right),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata),
    .audio_ready(audio_ready),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // model: lock streak count, time since RUN entry, queue of frames
  logic [FW-1:0] pend_q[$];
  logic [FW-1:0] cur_f = '0;
  bit m_lm = 0, m_ls = 0, ls_now = 0, acc = 0, m_run = 0;
  int m_streak = 0, m_n = 0, m_k = 0, m_b = 0;
  bit e_ready = 0, e_sready = 0, e_bclk = 0;
  bit e_lrclk = 1, e_sdata = 0, e_under = 0;

  always @(posedge clk) begin
    acc    = s_valid && e_sready;
    ls_now = m_ls;
    m_ls   = m_lm;
    m_lm   = pll_locked;
    e_under = 0;
    if (rst) begin
      m_lm = 0; m_ls = 0; m_run = 0; m_streak = 0;
      pend_q.delete();
      e_bclk = 0; e_lrclk = 1; e_sdata = 0;
    end else if (!m_run) begin
      m_streak = ls_now ? m_streak + 1 : 0;
      if (m_streak == LOCK_HOLD + 1) begin
        m_run = 1; m_n = 0; cur_f = '0;
        e_bclk = 0; e_lrclk = 1; e_sdata = 0;
      end
    end else if (!ls_now) begin
      m_run = 0; m_streak = 0;
      pend_q.delete();
      e_bclk = 0; e_lrclk = 1; e_sdata = 0;
    end else begin
      m_n++;
      e_bclk = ((m_n / BCLK_DIV) % 2) == 1;
      if (m_n % BPER == 0) begin
        m_k = m_n / BPER;
        m_b = (m_k - 1) % FW;
        e_lrclk = (m_b >= SLOT_W);
        if (m_b == 0) begin
          e_sdata = cur_f[0];
          if (pend_q.size() > 0) begin
            cur_f = pend_q.pop_front();
          end else begin
            cur_f = '0;
            e_under = 1;
          end
        end else begin
          e_sdata = cur_f[FW-m_b];
        end
      end
      if (acc)
        pend_q.push_back({s_left, {PADW{1'b0}}, s_right, {PADW{1'b0}}});
    end
    e_ready  = m_run;
    e_sready = m_run && (pend_q.size() == 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("audio_ready", 64'(audio_ready), 64'(e_ready));
      check("s_ready", 64'(s_ready), 64'(e_sready));
      check("bclk", 64'(i2s_bclk), 64'(e_bclk));
      check("lrclk", 64'(i2s_lrclk), 64'(e_lrclk));
      check("sdata", 64'(i2s_sdata), 64'(e_sdata));
      check("underrun", 64'(underrun), 64'(e_under));
    end
  end

  task automatic send_pair(input logic [DATA_W-1:0] l,
                           input logic [DATA_W-1:0] r, output int at);
    s_left = l; s_right = r; s_valid = 1'b1; at = -1;
    for (int i = 0; i < 1200 && at < 0; i++) begin
      if (s_ready === 1'b1) begin
        @(posedge clk); #1;
        at = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("send_accepted", 64'(at >= 0), 64'd1);
  endtask

  // record sdata/lrclk at each bclk fall of one frame, first bit at MSB
  task automatic capture(output logic [63:0] sd, output logic [63:0] lr,
                         output bit ok);
    logic pb, pl;
    int idx;
    sd = '0; lr = '0; idx = -1;
    pb = i2s_bclk; pl = i2s_lrclk;
    for (int i = 0; i < 1200 && idx < 64; i++) begin
      @(negedge clk);
      if (pb && !i2s_bclk) begin
        if (idx < 0 && pl && !i2s_lrclk) idx = 0;
        if (idx >= 0) begin
          sd[63-idx] = i2s_sdata;
          lr[63-idx] = i2s_lrclk;
          idx++;
        end
      end
      pb = i2s_bclk; pl = i2s_lrclk;
    end
    ok = (idx == 64);
  endtask

  task automatic wait_ready(input logic lvl, output int cnt);
    cnt = 0;
    while (cnt < 60 && audio_ready !== lvl) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  initial begin
    logic [63:0] sd, lr;
    logic pb, pl;
    bit ok;
    int t0, t1, t2, cnt, at;
    int acc_t[4];
    logic [DATA_W-1:0] lv[4];
    logic [DATA_W-1:0] rv[4];
    lv = '{24'h123456, 24'hFEDCBA, 24'h000001, 24'h800000};
    rv = '{24'h654321, 24'h0F0F0F, 24'hFFFFFF, 24'h7FFFFF};

    rst = 1'b1; pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_bclk", 64'(i2s_bclk), 64'd0);
    check("rst_lrclk", 64'(i2s_lrclk), 64'd1);
    check("rst_sdata", 64'(i2s_sdata), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_audio_ready", 64'(audio_ready), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);

    @(posedge clk); #1 rst = 1'b0;
    wait_ready(1'b1, cnt);
    check("lock_latency", 64'(cnt), 64'd11);

    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    while (cnt < 60 && audio_ready !== 1'b1) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 5) pll_locked = 1'b0;
      if (cnt == 6) pll_locked = 1'b1;
    end
    check("lock_glitch_latency", 64'(cnt), 64'd17);

    t0 = -1; t1 = -1; pb = i2s_bclk;
    for (int i = 0; i < 40 && t1 < 0; i++) begin
      @(negedge clk);
      if (!pb && i2s_bclk) begin
        if (t0 < 0) t0 = cyc; else t1 = cyc;
      end
      pb = i2s_bclk;
    end
    check("bclk_period", 64'(t1 - t0), 64'd4);

    t0 = -1; t1 = -1; t2 = -1;
    pb = i2s_bclk; pl = i2s_lrclk;
    for (int i = 0; i < 800 && t2 < 0; i++) begin
      @(negedge clk);
      if (pl != i2s_lrclk)
        check("lrclk_on_bclk_fall", 64'({pb, i2s_bclk}), 64'd2);
      if (pl && !i2s_lrclk) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 >= 0) t2 = cyc;
      end
      if (!pl && i2s_lrclk && t0 >= 0) t1 = cyc;
      pb = i2s_bclk; pl = i2s_lrclk;
    end
    check("lrclk_low", 64'(t1 - t0), 64'd128);
    check("lrclk_period", 64'(t2 - t0), 64'd256);

    t0 = -1; t1 = -1;
    for (int i = 0; i < 600 && t1 < 0; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) begin
        if (t0 < 0) t0 = cyc; else t1 = cyc;
      end
    end
    check("underrun_interval", 64'(t1 - t0), 64'd256);

    send_pair(24'h800001, 24'h7FFFFE, at);
    s_valid = 1'b0;
    capture(sd, lr, ok);
    check("frame_captured", 64'(ok), 64'd1);
    check("sdata_stream", sd, 64'h400000803FFFFF00);
    check("lrclk_stream", lr, 64'h00000000FFFFFFFF);

    for (int i = 0; i < 4; i++) begin
      send_pair(lv[i], rv[i], at);
      acc_t[i] = at;
    end
    s_valid = 1'b0;
    check("accept_gap_2_3", 64'(acc_t[2] - acc_t[1]), 64'd256);
    check("accept_gap_3_4", 64'(acc_t[3] - acc_t[2]), 64'd256);
    repeat (1100) @(negedge clk);

    send_pair(24'h3C3C3C, 24'hC3C3C3, at);
    s_valid = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk); #1 pll_locked = 1'b0;
    wait_ready(1'b0, cnt);
    check("unlock_latency", 64'(cnt), 64'd3);
    check("unlock_s_ready", 64'(s_ready), 64'd0);
    check("unlock_bclk", 64'(i2s_bclk), 64'd0);
    check("unlock_lrclk", 64'(i2s_lrclk), 64'd1);
    check("unlock_sdata", 64'(i2s_sdata), 64'd0);

    pll_locked = 1'b1;
    wait_ready(1'b1, cnt);
    check("relock_latency", 64'(cnt), 64'd11);
    send_pair(24'hA5A5A5, 24'h5A5A5A, at);
    s_valid = 1'b0;
    capture(sd, lr, ok);
    check("relock_frame_captured", 64'(ok), 64'd1);
    check("relock_sdata_stream", sd, 64'h52D2D2802D2D2D00);
    check("relock_lrclk_stream", lr, 64'h00000000FFFFFFFF);

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
